// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and frame constants shared by the UART transmitter and receiver
package uart_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } uart_state_t;
    localparam int   DATA_BITS = 8;
    localparam logic RX_IDLE   = 1'b1;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input, with selectable reset value
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, sync_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end
    assign q = sync_q;
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive stage with one-entry holding register and error pulses
// Defining UART_RX_PARITY_EN adds a parity bit after data bit 7 and the parity_err port.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       read_en,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);
    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    logic        rx_s;
    uart_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  sr_q, sr_d, data_q, data_d;
    logic        valid_q, valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic        done, par_ok;

    sync_2ff #(.RST_VAL(RX_IDLE)) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d, parity_err_q, parity_err_d;
    assign par_ok = !par_bad_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        sr_d        = sr_q;
        done        = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                state_d = rx_s ? S_IDLE : S_START;
            end
            S_START: if (cnt_q == MID) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (cnt_q == LAST) begin
                cnt_d       = '0;
                sr_d[idx_q] = rx_s;
                idx_d       = idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                state_d     = (idx_q == 3'(DATA_BITS - 1)) ? S_PARITY : S_DATA;
`else
                state_d     = (idx_q == 3'(DATA_BITS - 1)) ? S_STOP : S_DATA;
`endif
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (cnt_q == LAST) begin
                cnt_d     = '0;
                par_bad_d = rx_s != (^sr_q ^ PARITY_ODD);
                state_d   = S_STOP;
            end
`endif
            S_STOP: if (cnt_q == LAST) begin
                cnt_d       = '0;
                done        = rx_s & par_ok;
                frame_err_d = !rx_s;
                state_d     = rx_s ? S_IDLE : S_BREAK;
`ifdef UART_RX_PARITY_EN
                parity_err_d = par_bad_q;
                par_bad_d    = 1'b0;
`endif
            end
            S_BREAK: begin
                cnt_d   = '0;
                state_d = rx_s ? S_IDLE : S_BREAK;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        // a completing byte wins over a plain read; a full, unread register drops it
        data_d    = (done && (!valid_q || read_en)) ? sr_q : data_q;
        valid_d   = done | (valid_q & ~read_en);
        overrun_d = done & valid_q & ~read_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sr_q        <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sr_q        <= sr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scenario tasks with a byte scoreboard for uart_receiver at 16 clocks per bit
module tb_uart_receiver;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif

    logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, read_en = 1'b0;
    logic [7:0] data_out;
    logic       valid, frame_err, overrun;
    int         total = 0, bad = 0;
    int         cyc = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, rise_cyc = 0;
    logic       v_prev = 1'b0;
    logic [7:0] sb[$];
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`else
    logic       parity_err = 1'b0;
`endif

    uart_receiver #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .read_en  (read_en),
        .data_out (data_out),
        .valid    (valid),
        .frame_err(frame_err),
        .overrun  (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        fe_cnt <= fe_cnt + int'(frame_err);
        ov_cnt <= ov_cnt + int'(overrun);
        pe_cnt <= pe_cnt + int'(parity_err);
        if (valid && !v_prev) rise_cyc <= cyc;
        v_prev <= valid;
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (valid) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_read();
        read_en = 1'b1;
        @(posedge clk);
        #1;
        read_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data_out); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if ({frame_err, overrun} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b want=00", {frame_err, overrun}); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_clean();
        bit ok;
        int t0, fe0, ov0;
        logic [7:0] exp;
        fe0 = fe_cnt; ov0 = ov_cnt;
        t0 = cyc;
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_valid(ok);
        exp = sb.pop_front();
        total++; if (!ok) begin bad++; $display("FAIL clean_valid got=0 want=1 (timeout)"); end
        total++; if (rise_cyc - t0 !== LAT) begin bad++; $display("FAIL clean_latency got=%0d want=%0d", rise_cyc - t0, LAT); end
        total++; if (data_out !== exp) begin bad++; $display("FAIL clean_data got=%h want=%h", data_out, exp); end
        total++; if (fe_cnt != fe0 || ov_cnt != ov0) begin bad++; $display("FAIL clean_errs got=%0d/%0d want=0/0", fe_cnt - fe0, ov_cnt - ov0); end
        do_read();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL clean_read got=%b want=0", valid); end
    endtask

    task automatic test_glitch();
        bit ok;
        int fe0;
        logic [7:0] exp;
        fe0 = fe_cnt;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        total++; if (valid !== 1'b0 || fe_cnt != fe0) begin bad++; $display("FAIL glitch_quiet got=%b/%0d want=0/0", valid, fe_cnt - fe0); end
        sb.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        wait_valid(ok);
        exp = sb.pop_front();
        total++; if (!ok || data_out !== exp) begin bad++; $display("FAIL glitch_next got=%h want=%h", data_out, exp); end
        do_read();
    endtask

    task automatic test_frame_err();
        bit ok;
        int fe0;
        logic [7:0] exp;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL frame_err_count got=%0d want=1", fe_cnt - fe0); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL frame_err_valid got=%b want=0", valid); end
        rx = 1'b1;
        repeat (CPB) @(posedge clk);
        #1;
        sb.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        wait_valid(ok);
        exp = sb.pop_front();
        total++; if (!ok || data_out !== exp) begin bad++; $display("FAIL frame_err_next got=%h want=%h", data_out, exp); end
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL frame_err_after got=%0d want=1", fe_cnt - fe0); end
        do_read();
    endtask

    task automatic test_back_to_back();
        int ov0;
        logic [7:0] exp;
        ov0 = ov_cnt;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        exp = sb.pop_front();
        total++; if (data_out !== exp || valid !== 1'b1) begin bad++; $display("FAIL b2b_data got=%h/%b want=%h/1", data_out, valid, exp); end
        total++; if (ov_cnt - ov0 !== 1) begin bad++; $display("FAIL b2b_overrun got=%0d want=1", ov_cnt - ov0); end
        do_read();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_read got=%b want=0", valid); end
    endtask

    task automatic test_read_collide();
        bit ok;
        int ov0;
        logic [7:0] exp;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        wait_valid(ok);
        exp = sb.pop_front();
        total++; if (!ok || data_out !== exp) begin bad++; $display("FAIL collide_first got=%h want=%h", data_out, exp); end
        ov0 = ov_cnt;
        sb.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1;
                do_read();
            end
        join
        repeat (2) @(posedge clk);
        #1;
        exp = sb.pop_front();
        total++; if (data_out !== exp || valid !== 1'b1) begin bad++; $display("FAIL collide_data got=%h/%b want=%h/1", data_out, valid, exp); end
        total++; if (ov_cnt != ov0) begin bad++; $display("FAIL collide_overrun got=%0d want=0", ov_cnt - ov0); end
        do_read();
    endtask

    task automatic test_mid_reset();
        bit ok;
        int fe0, ov0;
        logic [7:0] exp;
        logic [7:0] d;
        send_frame(8'h33, 1'b1);
        d = 8'h77;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        rx = d[3];
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        fe0 = fe_cnt; ov0 = ov_cnt;
        @(negedge clk);
        total++; if (data_out !== 8'h00 || valid !== 1'b0) begin bad++; $display("FAIL midrst_out got=%h/%b want=00/0", data_out, valid); end
        repeat (CPB * 12) @(posedge clk);
        #1;
        total++; if (valid !== 1'b0 || fe_cnt != fe0 || ov_cnt != ov0) begin bad++; $display("FAIL midrst_quiet got=%b/%0d/%0d want=0/0/0", valid, fe_cnt - fe0, ov_cnt - ov0); end
        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_valid(ok);
        exp = sb.pop_front();
        total++; if (!ok || data_out !== exp) begin bad++; $display("FAIL midrst_next got=%h want=%h", data_out, exp); end
        do_read();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int pe0;
        logic [7:0] d;
        pe0 = pe_cnt;
        d = 8'h07;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (4) @(posedge clk);
        #1;
        total++; if (pe_cnt - pe0 !== 1) begin bad++; $display("FAIL parity_pulse got=%0d want=1", pe_cnt - pe0); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL parity_valid got=%b want=0", valid); end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_clean();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_read_collide();
        test_mid_reset();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
UART receive stage paired with the team's transmitter. It consumes the serial `rx` line (idle-high, 1 start bit, 8 data bits LSB first, 1 stop bit) and rebuilds each byte. It presents bytes through a one-entry holding register with a valid/read handshake toward the downstream consumer. It reports framing and overrun errors as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and >= 4.
- PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- read_en  input  1  consumer takes `data_out` this cycle; only has effect while `valid` = 1.
- data_out  output  8  last received byte.
- valid  output  1  `data_out` holds an unread byte.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while holding register full and not being read.
- parity_err  output  1  one-cycle pulse; present only with UART_RX_PARITY_EN.

Behaviour:
- Reset: synchronous, active-high; `rst` sampled on posedge `clk`.
  - Synchronizer flops reset to 1.
  - State goes to IDLE; counters and shift register reset to 0.
  - `data_out` = 0x00, `valid` = 0, `frame_err` = 0, `overrun` = 0, `parity_err` = 0.
  - Reset mid-frame abandons the frame; no pulse is produced.
- Input path: `rx` passes through a 2-flop synchronizer (`rx_s`). All sampling uses `rx_s`, which adds 2 cycles of fixed latency.
- Counters:
  - Bit-timer `cnt` is $clog2(CLKS_PER_BIT) bits wide.
  - Bit index `idx` is 3 bits.
  - Shift register `sr` is 8 bits.
- State machine (3-bit encoding):
  - IDLE: when `rx_s` = 0, go to START with `cnt` = 0.
  - START: count to CLKS_PER_BIT/2-1 (mid start bit), then sample `rx_s`.
    - Sample is 0: go to DATA with `cnt` = 0, `idx` = 0.
    - Sample is 1: glitch; return to IDLE, no output, no error.
  - DATA: count to CLKS_PER_BIT-1, sample `rx_s` into `sr[idx]`, then increment `idx`.
    - After the sample with `idx` = 7: go to STOP (or PARITY, see Optional Feature).
  - STOP: count to CLKS_PER_BIT-1, then sample.
    - Sample is 1: byte complete; return to IDLE (mid stop bit).
    - Sample is 0: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rx_s` = 1, then go to IDLE. This stops a held-low line from being re-read as endless start bits.
- Holding register, evaluated in the cycle a byte completes:
  - `valid` = 0: load `data_out` = `sr`; `valid` = 1 on the next edge.
  - `valid` = 1 and `read_en` = 1: load the new byte; `valid` stays 1; no overrun.
  - `valid` = 1 and `read_en` = 0: keep the old byte, drop the new one, pulse `overrun`.
- Read handshake: `read_en` = 1 with `valid` = 1 and no completing byte clears `valid` on the next edge. `read_en` while `valid` = 0 is ignored.
- Latency: `valid` rises on the edge after the stop-bit mid-sample, about 9.5·CLKS_PER_BIT + 3 cycles after the start-bit falling edge on `rx`.
- Error pulses are never asserted in the same cycle as a `valid` load for the same frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame carries 1 parity bit after data bit 7.
  - State PARITY is inserted between DATA and STOP; it samples after CLKS_PER_BIT cycles.
  - Expected parity is ^`sr` XOR PARITY_ODD. On mismatch, the stop bit is still checked, the byte is discarded, and `parity_err` pulses at the stop-bit sample.
  - `parity_err` port exists.
- Undefined: 10-bit frame; no PARITY state; no `parity_err` port.

Decomposition:
- Package `uart_pkg`:
  - State encodings S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK.
  - Constants DATA_BITS = 8, RX_IDLE = 1'b1.
  - Shared with the transmitter.
- Sub-module `sync_2ff`: 1-bit two-flop synchronizer with reset value parameter; reused for other asynchronous inputs.

Test Plan (CLKS_PER_BIT = 16):
- Clean frame 0xA5 → `valid` rises ~155 cycles after the start edge; `data_out` = 0xA5; no error pulses. Assert `read_en` → `valid` = 0 next cycle.
- `rx` low for 4 cycles, then high → no `valid`, no error; FSM back in IDLE. Following frame 0x0F is received correctly.
- Frame 0x3C with stop bit low, line held low 40 cycles → single `frame_err` pulse; `valid` stays 0; no new frame until `rx` goes high. Next frame 0x81 is received correctly.
- Back-to-back 0x11 then 0x22, no `read_en` → `data_out` = 0x11; `overrun` pulses once at the 0x22 stop sample. Then `read_en` → `valid` = 0.
- 0x11 pending; `read_en` asserted in the exact cycle 0x22 completes → `data_out` = 0x22, `valid` stays 1, `overrun` = 0.
- `rst` pulsed during data bit 3 → all outputs 0, `valid` = 0. Next frame 0x5A gives `data_out` = 0x5A. With UART_RX_PARITY_EN and PARITY_ODD = 0: frame 0x07 with parity bit 0 → `parity_err` pulse, `valid` stays 0.
